conv_transpose3d_scatter_engine: RTL and testbench

- Single-channel 3D transposed-convolution engine: per-job loads a KxKxK weight cube, scatter-accumulates every input voxel into an on-chip output volume, then streams the result.
- Parametrised successor of the fixed 32-bit pass-through conv-transpose operator stub. Sits between the activation streamer and the output writer in the operator datapath.
- Output dims: OD=(ID-1)*STRIDE+K, likewise OH, OW. Padding=0, output_padding=0, dilation=1, groups=1, no bias.

---
 rtl/conv_transpose3d_scatter_engine.sv | 271 +++++++++++++++++++++++++++
 tb/tb_conv_transpose3d_scatter_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_transpose3d_scatter_engine.sv
// Single-channel 3D transposed-convolution engine.
// Loads a KxKxK weight cube, clears the output volume, scatter-accumulates
// every input voxel into it one kernel tap per cycle, then streams the result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// LOAD_W  | accepting K^3 weight beats (kd,kh,kw order, kw fastest)
// CLEAR   | zeroing one accumulator entry per cycle
// ACCUM   | accepting voxels; each one sweeps K^3 taps into the volume
// DRAIN   | streaming the accumulator volume in raster order
module conv_transpose3d_scatter_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int ID     = 2,
  parameter int IH     = 2,
  parameter int IW     = 2,
  parameter int K      = 2,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int OD   = (ID - 1) * STRIDE + K;
  localparam int OH   = (IH - 1) * STRIDE + K;
  localparam int OW   = (IW - 1) * STRIDE + K;
  localparam int NOUT = OD * OH * OW;
  localparam int NTAP = K * K * K;
  localparam int AW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int MAX1 = (ID > IH) ? ID : IH;
  localparam int MAX2 = (IW > K) ? IW : K;
  localparam int MAXI = (MAX1 > MAX2) ? MAX1 : MAX2;
  localparam int CW   = $clog2(MAXI + 1);
  localparam int PW   = 2 * DATA_W;

  if (STRIDE < 1 || STRIDE > K) begin : g_bad_stride
    $error("conv_transpose3d_scatter_engine: STRIDE must lie in 1..K");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  // tap_q doubles as the weight-load index in LOAD_W and the flat tap index in ACCUM
  logic [TW-1:0] tap_q, tap_d;
  logic [CW-1:0] kd_q, kd_d, kh_q, kh_d, kw_q, kw_d;
  logic [CW-1:0] vd_q, vd_d, vh_q, vh_d, vw_q, vw_d;
  // idx_q walks the volume in CLEAR and again in DRAIN
  logic [AW-1:0] idx_q, idx_d;
  logic          sweep_q, sweep_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;

  logic signed [DATA_W-1:0] w_mem   [NTAP];
  logic        [ACC_W-1:0]  acc_mem [NOUT];

  logic [AW-1:0]        tap_addr;
  logic signed [PW-1:0] prod;
  logic [ACC_W-1:0]     tap_sum;
  logic                 w_fire, tap_we, clr_we, last_tap, last_vox;

  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign done     = done_q;

  // Scatter address of the current tap and the read-modify-write sum.
  always_comb begin
    tap_addr = AW'(((int'(vd_q) * STRIDE + int'(kd_q)) * OH
                   + int'(vh_q) * STRIDE + int'(kh_q)) * OW
                   + int'(vw_q) * STRIDE + int'(kw_q));
    prod     = PW'(x_q) * PW'(w_mem[tap_q]);
    tap_sum  = acc_mem[tap_addr] + ACC_W'(prod);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    kd_d       = kd_q;
    kh_d       = kh_q;
    kw_d       = kw_q;
    vd_d       = vd_q;
    vh_d       = vh_q;
    vw_d       = vw_q;
    idx_d      = idx_q;
    sweep_d    = sweep_q;
    x_d        = x_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
    tap_we     = 1'b0;
    clr_we     = 1'b0;

    w_ready   = (state_q == S_LOAD_W);
    in_ready  = (state_q == S_ACCUM) && !sweep_q;
    out_valid = (state_q == S_DRAIN);
    busy      = (state_q != S_IDLE);
    w_fire    = w_valid && w_ready;
    last_tap  = (tap_q == TW'(NTAP - 1));
    last_vox  = (vd_q == CW'(ID - 1)) && (vh_q == CW'(IH - 1)) && (vw_q == CW'(IW - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          tap_d   = '0;
        end
      end
      S_LOAD_W: begin
        if (w_fire) begin
          if (last_tap) begin
            tap_d   = '0;
            idx_d   = '0;
            state_d = S_CLEAR;
          end else begin
            tap_d = tap_q + TW'(1);
          end
        end
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        if (idx_q == AW'(NOUT - 1)) begin
          idx_d   = '0;
          vd_d    = '0;
          vh_d    = '0;
          vw_d    = '0;
          sweep_d = 1'b0;
          state_d = S_ACCUM;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_ACCUM: begin
        if (!sweep_q) begin
          if (in_valid) begin
            x_d     = in_data;
            sweep_d = 1'b1;
            tap_d   = '0;
            kd_d    = '0;
            kh_d    = '0;
            kw_d    = '0;
          end
        end else begin
          tap_we = 1'b1;
          tap_d  = tap_q + TW'(1);
          if (kw_q == CW'(K - 1)) begin
            kw_d = '0;
            if (kh_q == CW'(K - 1)) begin
              kh_d = '0;
              kd_d = kd_q + CW'(1);
            end else begin
              kh_d = kh_q + CW'(1);
            end
          end else begin
            kw_d = kw_q + CW'(1);
          end
          if (last_tap) begin
            sweep_d = 1'b0;
            if (vw_q == CW'(IW - 1)) begin
              vw_d = '0;
              if (vh_q == CW'(IH - 1)) begin
                vh_d = '0;
                vd_d = vd_q + CW'(1);
              end else begin
                vh_d = vh_q + CW'(1);
              end
            end else begin
              vw_d = vw_q + CW'(1);
            end
            if (last_vox) begin
              state_d    = S_DRAIN;
              idx_d      = '0;
              // entry 0 may be written by this very tap, so forward it
              out_data_d = (tap_addr == '0) ? tap_sum : acc_mem[0];
              out_last_d = (NOUT == 1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == AW'(NOUT - 1)) begin
            state_d    = S_IDLE;
            idx_d      = '0;
            out_data_d = '0;
            out_last_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            idx_d      = idx_q + AW'(1);
            out_data_d = acc_mem[idx_q + AW'(1)];
            out_last_d = ((idx_q + AW'(1)) == AW'(NOUT - 1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tap_q      <= '0;
      kd_q       <= '0;
      kh_q       <= '0;
      kw_q       <= '0;
      vd_q       <= '0;
      vh_q       <= '0;
      vw_q       <= '0;
      idx_q      <= '0;
      sweep_q    <= 1'b0;
      x_q        <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      kd_q       <= kd_d;
      kh_q       <= kh_d;
      kw_q       <= kw_d;
      vd_q       <= vd_d;
      vh_q       <= vh_d;
      vw_q       <= vw_d;
      idx_q      <= idx_d;
      sweep_q    <= sweep_d;
      x_q        <= x_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
    end
  end

  // Weight and accumulator storage; contents are not reset, CLEAR zeroes the volume.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_fire) begin
        w_mem[tap_q] <= w_data;
      end
      if (clr_we) begin
        acc_mem[idx_q] <= '0;
      end else if (tap_we) begin
        acc_mem[tap_addr] <= tap_sum;
      end
    end
  end

endmodule

// File: tb/tb_conv_transpose3d_scatter_engine.sv
// Bench for conv_transpose3d_scatter_engine: three parameterisations
// (default, stride 2, narrow asymmetric) against a loop-nest reference model.
module tb_conv_transpose3d_scatter_engine;

  localparam int KK = 2;
  localparam int P_ID [3] = '{2, 2, 2};
  localparam int P_IH [3] = '{2, 2, 1};
  localparam int P_IW [3] = '{2, 2, 3};
  localparam int P_S  [3] = '{1, 2, 1};
  localparam int P_AW [3] = '{24, 24, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_v [3];
  logic       w_valid_v [3];
  logic       in_valid_v [3];
  logic       out_ready_v [3];
  logic [7:0] w_data_v [3];
  logic [7:0] in_data_v [3];
  logic       w_ready_v [3];
  logic       in_ready_v [3];
  logic       out_valid_v [3];
  logic       out_last_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic [23:0] od0, od1;
  logic [15:0] od2;

  conv_transpose3d_scatter_engine u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .w_valid(w_valid_v[0]), .w_data(w_data_v[0]), .w_ready(w_ready_v[0]),
    .in_valid(in_valid_v[0]), .in_data(in_data_v[0]), .in_ready(in_ready_v[0]),
    .out_valid(out_valid_v[0]), .out_data(od0), .out_last(out_last_v[0]),
    .out_ready(out_ready_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  conv_transpose3d_scatter_engine #(.STRIDE(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .w_valid(w_valid_v[1]), .w_data(w_data_v[1]), .w_ready(w_ready_v[1]),
    .in_valid(in_valid_v[1]), .in_data(in_data_v[1]), .in_ready(in_ready_v[1]),
    .out_valid(out_valid_v[1]), .out_data(od1), .out_last(out_last_v[1]),
    .out_ready(out_ready_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  conv_transpose3d_scatter_engine #(.ACC_W(16), .ID(2), .IH(1), .IW(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .w_valid(w_valid_v[2]), .w_data(w_data_v[2]), .w_ready(w_ready_v[2]),
    .in_valid(in_valid_v[2]), .in_data(in_data_v[2]), .in_ready(in_ready_v[2]),
    .out_valid(out_valid_v[2]), .out_data(od2), .out_last(out_last_v[2]),
    .out_ready(out_ready_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  int     checks;
  int     failures;
  int     wt [8];
  int     vx [16];
  longint expv [64];
  longint got [64];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint get_od(input int inst);
    case (inst)
      0:       return longint'($signed(od0));
      1:       return longint'($signed(od1));
      default: return longint'($signed(od2));
    endcase
  endfunction

  function automatic int rnd8();
    logic signed [7:0] b;
    b = 8'($urandom);
    return int'(b);
  endfunction

  function automatic int nout_of(input int inst);
    return ((P_ID[inst] - 1) * P_S[inst] + KK) * ((P_IH[inst] - 1) * P_S[inst] + KK)
         * ((P_IW[inst] - 1) * P_S[inst] + KK);
  endfunction

  // Reference: direct loop nest over voxels and taps, then wrap to ACC_W bits.
  task automatic model(input int inst);
    int s, oh, ow, ad;
    longint one, mask, v;
    s  = P_S[inst];
    oh = (P_IH[inst] - 1) * s + KK;
    ow = (P_IW[inst] - 1) * s + KK;
    for (int a = 0; a < 64; a++) expv[a] = 0;
    for (int d = 0; d < P_ID[inst]; d++)
      for (int h = 0; h < P_IH[inst]; h++)
        for (int w = 0; w < P_IW[inst]; w++)
          for (int kd = 0; kd < KK; kd++)
            for (int kh = 0; kh < KK; kh++)
              for (int kw = 0; kw < KK; kw++) begin
                ad = ((d * s + kd) * oh + h * s + kh) * ow + w * s + kw;
                expv[ad] += longint'(vx[(d * P_IH[inst] + h) * P_IW[inst] + w])
                          * longint'(wt[(kd * KK + kh) * KK + kw]);
              end
    one  = 1;
    mask = (one <<< P_AW[inst]) - 1;
    for (int a = 0; a < 64; a++) begin
      v = expv[a] & mask;
      if (v >= (one <<< (P_AW[inst] - 1))) v -= (one <<< P_AW[inst]);
      expv[a] = v;
    end
  endtask

  task automatic run_job(input int inst, input bit stall, input bit proto, input int abort_at);
    int nout, nvox, i, cyc, lowc, k;
    bit r, orr, pstall, pl;
    longint pd;
    nout = nout_of(inst);
    nvox = P_ID[inst] * P_IH[inst] * P_IW[inst];

    @(negedge clk);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    chk("busy_after_start", busy_v[inst], 1);

    i = 0;
    cyc = 0;
    while (i < 8 && cyc < 500) begin
      if (proto) begin
        in_valid_v[inst] = 1'b1;
        in_data_v[inst]  = 8'h77;
      end
      w_valid_v[inst] = ($urandom_range(0, 3) != 0);
      w_data_v[inst]  = 8'(wt[i]);
      r = w_valid_v[inst] && w_ready_v[inst];
      @(negedge clk);
      cyc++;
      if (r) i++;
    end
    chk("weight_beats", i, 8);
    w_valid_v[inst] = proto;
    w_data_v[inst]  = 8'h3C;

    for (int j = 0; j < nvox; j++) begin
      if (j == abort_at) begin
        rst_n = 1'b0;
        start_v[inst] = 1'b1;
        in_valid_v[inst] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start_v[inst] = 1'b0;
        in_valid_v[inst] = 1'b0;
        w_valid_v[inst] = 1'b0;
        chk("rst_w_ready", w_ready_v[inst], 0);
        chk("rst_in_ready", in_ready_v[inst], 0);
        chk("rst_out_valid", out_valid_v[inst], 0);
        chk("rst_out_data", get_od(inst), 0);
        chk("rst_out_last", out_last_v[inst], 0);
        chk("rst_busy", busy_v[inst], 0);
        chk("rst_done", done_v[inst], 0);
        @(negedge clk);
        chk("rst_start_ignored", busy_v[inst], 0);
        return;
      end
      if (!proto && $urandom_range(0, 2) == 0) begin
        in_valid_v[inst] = 1'b0;
        @(negedge clk);
      end
      in_valid_v[inst] = 1'b1;
      in_data_v[inst]  = 8'(vx[j]);
      cyc = 0;
      while (!in_ready_v[inst] && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      chk("in_ready_wait", in_ready_v[inst], 1);
      @(negedge clk);
      in_data_v[inst] = 8'h5A;
      lowc = 0;
      while (!in_ready_v[inst] && !out_valid_v[inst] && lowc < 100) begin
        if (proto && j == 1) start_v[inst] = (lowc == 0);
        lowc++;
        @(negedge clk);
      end
      start_v[inst] = 1'b0;
      chk("in_ready_low_cycles", lowc, 8);
    end
    in_valid_v[inst] = 1'b0;

    k = 0;
    cyc = 0;
    pstall = 1'b0;
    pd = 0;
    pl = 1'b0;
    while (k < nout && cyc < 1000) begin
      orr = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      out_ready_v[inst] = orr;
      if (pstall) begin
        chk("stall_valid_held", out_valid_v[inst], 1);
        chk("stall_data_stable", get_od(inst), pd);
        chk("stall_last_stable", out_last_v[inst], pl);
      end
      if (out_valid_v[inst]) begin
        if (orr) begin
          got[k] = get_od(inst);
          chk("out_data", got[k], expv[k]);
          chk("out_last", out_last_v[inst], (k == nout - 1));
          k++;
        end
        pstall = !orr;
        pd = get_od(inst);
        pl = out_last_v[inst];
      end
      @(negedge clk);
      cyc++;
    end
    out_ready_v[inst] = 1'b0;
    w_valid_v[inst]   = 1'b0;
    chk("drain_beats", k, nout);
    chk("out_valid_after_last", out_valid_v[inst], 0);
    chk("done_pulse", done_v[inst], 1);
    chk("busy_after_done", busy_v[inst], 0);
    @(negedge clk);
    chk("done_single_cycle", done_v[inst], 0);
  endtask

  task automatic load_ones();
    for (int i = 0; i < 8; i++) wt[i] = 1;
    for (int i = 0; i < 16; i++) vx[i] = 1;
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) wt[i] = rnd8();
    for (int i = 0; i < 16; i++) vx[i] = rnd8();
  endtask

  function automatic longint sum_got(input int n);
    longint s;
    s = 0;
    for (int a = 0; a < n; a++) s += got[a];
    return s;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int n = 0; n < 3; n++) begin
      start_v[n] = 1'b0;
      w_valid_v[n] = 1'b0;
      in_valid_v[n] = 1'b0;
      out_ready_v[n] = 1'b0;
      w_data_v[n] = 8'h00;
      in_data_v[n] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("reset_w_ready", w_ready_v[0], 0);
    chk("reset_in_ready", in_ready_v[0], 0);
    chk("reset_out_valid", out_valid_v[0], 0);
    chk("reset_out_data", get_od(0), 0);
    chk("reset_out_last", out_last_v[0], 0);
    chk("reset_busy", busy_v[0], 0);
    chk("reset_done", done_v[0], 0);
    chk("reset_busy1", busy_v[1], 0);
    chk("reset_busy2", busy_v[2], 0);
    rst_n = 1'b1;

    // all-ones cube, stride 1
    load_ones();
    model(0);
    run_job(0, 1'b0, 1'b0, -1);
    chk("ones_corner", got[0], 1);
    chk("ones_edge_centre", got[1], 2);
    chk("ones_face_centre", got[4], 4);
    chk("ones_centre", got[13], 8);
    chk("ones_sum", sum_got(27), 64);

    // stride 2, single nonzero voxel
    for (int i = 0; i < 8; i++) wt[i] = i + 1;
    for (int i = 0; i < 16; i++) vx[i] = 0;
    vx[0] = 3;
    model(1);
    run_job(1, 1'b0, 1'b0, -1);
    chk("s2_first", got[0], 3);
    chk("s2_kd1", got[16], 15);
    chk("s2_last_tap", got[21], 24);
    chk("s2_far", got[63], 0);
    chk("s2_sum", sum_got(64), 108);

    // signed extremes
    for (int i = 0; i < 8; i++) wt[i] = -128;
    for (int i = 0; i < 16; i++) vx[i] = 0;
    vx[0] = -128;
    model(0);
    run_job(0, 1'b0, 1'b0, -1);
    chk("ext_origin", got[0], 16384);
    chk("ext_centre", got[13], 16384);
    chk("ext_untouched", got[26], 0);

    // overlap wraps in a 16-bit accumulator
    vx[1] = -128;
    model(2);
    run_job(2, 1'b0, 1'b0, -1);
    chk("wrap_single", got[0], 16384);
    chk("wrap_overlap", got[1], -32768);
    chk("wrap_single_r", got[2], 16384);

    // output backpressure
    load_ones();
    model(0);
    run_job(0, 1'b1, 1'b0, -1);
    chk("bp_centre", got[13], 8);
    chk("bp_sum", sum_got(27), 64);

    // stray valids and start during the job
    load_random();
    model(0);
    run_job(0, 1'b0, 1'b1, -1);

    // reset mid-accumulation, then a fresh all-ones job
    load_random();
    run_job(0, 1'b0, 1'b0, 3);
    load_ones();
    model(0);
    run_job(0, 1'b0, 1'b0, -1);
    chk("post_rst_centre", got[13], 8);
    chk("post_rst_sum", sum_got(27), 64);

    // randomized jobs across all configurations
    for (int r = 0; r < 6; r++) begin
      load_random();
      model(r % 3);
      run_job(r % 3, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
